// File: rtl/rf_bus_pkg.sv
// Shared constants and helper functions for the bus-mapped register file.
package rf_bus_pkg;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0100;
    localparam int          DEFAULT_NREG      = 10;

    // Widest data path the byte-merge helper supports; callers cast in and out.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Window test done one bit wider than the address so base+nreg never wraps.
    // Addresses up to 32 bits are supported.
    function automatic logic rf_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int          nreg);
        logic [32:0] addrX;
        logic [32:0] lowX;
        logic [32:0] highX;
        addrX = {1'b0, addr};
        lowX  = {1'b0, base};
        highX = lowX + 33'(nreg);
        return (addrX >= lowX) && (addrX < highX);
    endfunction

    // Offset of an address from the window base; only meaningful on a hit.
    function automatic logic [31:0] rf_index(input logic [31:0] addr,
                                             input logic [31:0] base);
        return addr - base;
    endfunction

    // Replace each byte of oldData whose strobe bit is set with the byte of newData.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(input logic [MAX_DATA_W-1:0] oldData,
                                                          input logic [MAX_DATA_W-1:0] newData,
                                                          input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_DATA_W-1:0] result;
        result = oldData;
        for (int k = 0; k < MAX_STRB_W; k++) begin
            if (strb[k]) begin
                result[8*k +: 8] = newData[8*k +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rf_bus_regfile_rdport.sv
// One registered read port: decodes its address, applies the write-first
// bypass and clear, and holds the data/valid/error flops.
module rf_bus_rdport
    import rf_bus_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                NREG      = DEFAULT_NREG,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                IDX_W     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] regs_i [NREG],
    input  logic              clr_i,
    input  logic              byp_en_i,
    input  logic [IDX_W-1:0]  byp_idx_i,
    input  logic [DATA_W-1:0] byp_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              err_o
);

    logic              rdHit;
    logic [IDX_W-1:0]  rdIdx;
    logic [DATA_W-1:0] rdVal;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              err_q;

    // Value the addressed register will hold after this edge's clear or write.
    always_comb begin
        rdHit = rf_hit(32'(addr_i), 32'(BASE_ADDR), NREG);
        rdIdx = IDX_W'(rf_index(32'(addr_i), 32'(BASE_ADDR)));
        rdVal = '0;
        if (rdHit && !clr_i) begin
            if (byp_en_i && (byp_idx_i == rdIdx)) begin
                rdVal = byp_data_i;
            end else begin
                rdVal = regs_i[rdIdx];
            end
        end
    end

    // Capture a read result; with no request the data holds and the flags drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (re_i) begin
            data_q  <= rdVal;
            valid_q <= 1'b1;
            err_q   <= !rdHit;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/rf_bus_regfile.sv
// Bus-mapped register file: NREG registers of DATA_W bits at BASE_ADDR,
// one byte-strobed write port and two registered read ports.
module rf_bus_regfile
    import rf_bus_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                NREG      = DEFAULT_NREG,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_strb,
    output logic                  w_err,
    input  logic                  re0,
    input  logic                  re1,
    input  logic [ADDR_W-1:0]     r_addr0,
    input  logic [ADDR_W-1:0]     r_addr1,
    output logic [DATA_W-1:0]     r_data0,
    output logic [DATA_W-1:0]     r_data1,
    output logic                  r_valid0,
    output logic                  r_valid1,
    output logic                  r_err0,
    output logic                  r_err1
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic              w_err_q;
    logic              wrHit;
    logic [IDX_W-1:0]  wrIdx;
    logic [DATA_W-1:0] wrOld;
    logic [DATA_W-1:0] wrMerged;
    logic              wrEn;

    // Decode the write and build the byte-merged value for the target register.
    always_comb begin
        wrHit    = rf_hit(32'(w_addr), 32'(BASE_ADDR), NREG);
        wrIdx    = IDX_W'(rf_index(32'(w_addr), 32'(BASE_ADDR)));
        wrOld    = wrHit ? regs_q[wrIdx] : '0;
        wrMerged = DATA_W'(merge_bytes(MAX_DATA_W'(wrOld), MAX_DATA_W'(w_data),
                                       MAX_STRB_W'(w_strb)));
        wrEn     = we && wrHit && !clr;
    end

    // Register storage: clear wins over a write; a miss only raises w_err.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            w_err_q <= 1'b0;
        end else begin
            if (clr) begin
                for (int i = 0; i < NREG; i++) begin
                    regs_q[i] <= '0;
                end
            end else if (wrEn) begin
                regs_q[wrIdx] <= wrMerged;
            end
            w_err_q <= we && !wrHit;
        end
    end

    assign w_err = w_err_q;

    rf_bus_rdport #(
        .DATA_W    (DATA_W),
        .NREG      (NREG),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_rdport0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .re_i       (re0),
        .addr_i     (r_addr0),
        .regs_i     (regs_q),
        .clr_i      (clr),
        .byp_en_i   (wrEn),
        .byp_idx_i  (wrIdx),
        .byp_data_i (wrMerged),
        .data_o     (r_data0),
        .valid_o    (r_valid0),
        .err_o      (r_err0)
    );

    rf_bus_rdport #(
        .DATA_W    (DATA_W),
        .NREG      (NREG),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_rdport1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .re_i       (re1),
        .addr_i     (r_addr1),
        .regs_i     (regs_q),
        .clr_i      (clr),
        .byp_en_i   (wrEn),
        .byp_idx_i  (wrIdx),
        .byp_data_i (wrMerged),
        .data_o     (r_data1),
        .valid_o    (r_valid1),
        .err_o      (r_err1)
    );

endmodule

// File: tb/tb_rf_bus_regfile.sv
// Self-checking bench for rf_bus_regfile against a register-array model.
module tb_rf_bus_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr;
    logic        we;
    logic [15:0] w_addr;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_err;
    logic        re0;
    logic        re1;
    logic [15:0] r_addr0;
    logic [15:0] r_addr1;
    logic [63:0] r_data0;
    logic [63:0] r_data1;
    logic        r_valid0;
    logic        r_valid1;
    logic        r_err0;
    logic        r_err1;

    int checks = 0;
    int errors = 0;

    // Reference state: ten 64-bit registers at 0x0100..0x0109
    logic [63:0] model [10];
    logic        expWerr;
    logic        expValid0;
    logic        expValid1;
    logic        expErr0;
    logic        expErr1;
    logic [63:0] expData0;
    logic [63:0] expData1;

    rf_bus_regfile dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .we       (we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_strb   (w_strb),
        .w_err    (w_err),
        .re0      (re0),
        .re1      (re1),
        .r_addr0  (r_addr0),
        .r_addr1  (r_addr1),
        .r_data0  (r_data0),
        .r_data1  (r_data1),
        .r_valid0 (r_valid0),
        .r_valid1 (r_valid1),
        .r_err0   (r_err0),
        .r_err1   (r_err1)
    );

    always #5 clk = ~clk;

    function automatic bit tbHit(input logic [15:0] a);
        return (int'(a) >= 256) && (int'(a) < 266);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".w_err"},    64'(w_err),    64'(expWerr));
        checkOutput({tag, ".r_valid0"}, 64'(r_valid0), 64'(expValid0));
        checkOutput({tag, ".r_valid1"}, 64'(r_valid1), 64'(expValid1));
        checkOutput({tag, ".r_err0"},   64'(r_err0),   64'(expErr0));
        checkOutput({tag, ".r_err1"},   64'(r_err1),   64'(expErr1));
        checkOutput({tag, ".r_data0"},  r_data0,       expData0);
        checkOutput({tag, ".r_data1"},  r_data1,       expData1);
    endtask

    task automatic modelReset();
        foreach (model[i]) model[i] = '0;
        expWerr   = 1'b0;
        expValid0 = 1'b0;
        expValid1 = 1'b0;
        expErr0   = 1'b0;
        expErr1   = 1'b0;
        expData0  = '0;
        expData1  = '0;
    endtask

    // Drive one cycle, advance the model, clock it and compare every output
    task automatic applyStimulus(input bit iWe, input bit iClr, input logic [15:0] iWaddr,
                                 input logic [63:0] iWdata, input logic [7:0] iStrb,
                                 input bit iRe0, input logic [15:0] iA0,
                                 input bit iRe1, input logic [15:0] iA1, input string tag);
        we      = iWe;
        clr     = iClr;
        w_addr  = iWaddr;
        w_data  = iWdata;
        w_strb  = iStrb;
        re0     = iRe0;
        r_addr0 = iA0;
        re1     = iRe1;
        r_addr1 = iA1;
        if (iClr) begin
            foreach (model[i]) model[i] = '0;
        end else if (iWe && tbHit(iWaddr)) begin
            for (int k = 0; k < 8; k++) begin
                if (iStrb[k]) model[int'(iWaddr) - 256][8*k +: 8] = iWdata[8*k +: 8];
            end
        end
        expWerr   = iWe && !tbHit(iWaddr);
        expValid0 = iRe0;
        expErr0   = iRe0 && !tbHit(iA0);
        if (iRe0) expData0 = tbHit(iA0) ? model[int'(iA0) - 256] : 64'h0;
        expValid1 = iRe1;
        expErr1   = iRe1 && !tbHit(iA1);
        if (iRe1) expData1 = tbHit(iA1) ? model[int'(iA1) - 256] : 64'h0;
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    function automatic logic [15:0] pickAddr();
        if ($urandom_range(0, 9) < 8) return 16'(16'h00FE + $urandom_range(0, 14));
        return 16'($urandom);
    endfunction

    initial begin
        modelReset();
        reset_n = 1'b0;
        clr = 0; we = 0; w_addr = 0; w_data = 0; w_strb = 0;
        re0 = 0; re1 = 0; r_addr0 = 0; r_addr1 = 0;

        // Reset holds every output at zero whatever the inputs do
        for (int i = 0; i < 3; i++) begin
            we      = 1'($urandom);
            clr     = 1'($urandom);
            w_addr  = pickAddr();
            w_data  = {$urandom, $urandom};
            w_strb  = 8'($urandom);
            re0     = 1'($urandom);
            re1     = 1'($urandom);
            r_addr0 = pickAddr();
            r_addr1 = pickAddr();
            @(posedge clk);
            #1;
            checkAll("reset_hold");
        end
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(0, 0, 16'h0000, 64'h0, 8'h00, 1, 16'h0100, 1, 16'h0100, "post_reset_read");

        // Window boundaries
        applyStimulus(1, 0, 16'h0100, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 16'h0, 0, 16'h0, "bnd_wr_lo");
        applyStimulus(1, 0, 16'h0109, 64'h1111, 8'hFF, 0, 16'h0, 0, 16'h0, "bnd_wr_hi");
        applyStimulus(0, 0, 16'h0000, 64'h0, 8'h00, 1, 16'h0100, 1, 16'h0109, "bnd_rd");
        checkOutput("bnd_rd_lo_value", r_data0, 64'hDEAD_BEEF_0123_4567);
        checkOutput("bnd_rd_hi_value", r_data1, 64'h1111);
        applyStimulus(1, 0, 16'h010A, 64'h9999, 8'hFF, 0, 16'h0, 0, 16'h0, "bnd_wr_miss");
        checkOutput("bnd_wr_miss_flag", 64'(w_err), 64'h1);
        applyStimulus(0, 0, 16'h0000, 64'h0, 8'h00, 1, 16'h00FF, 1, 16'h0109, "bnd_rd_miss");
        checkOutput("bnd_rd_miss_flag", 64'(r_err0), 64'h1);

        // Byte strobes
        applyStimulus(1, 0, 16'h0103, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 16'h0, 0, 16'h0, "strb_fill");
        applyStimulus(1, 0, 16'h0103, 64'h0, 8'h0F, 0, 16'h0, 0, 16'h0, "strb_low");
        applyStimulus(1, 0, 16'h0103, 64'h0, 8'h00, 1, 16'h0103, 0, 16'h0, "strb_none");
        checkOutput("strb_value", r_data0, 64'hFFFF_FFFF_0000_0000);

        // Same-cycle write/read bypass
        applyStimulus(1, 0, 16'h0104, 64'h4444, 8'hFF, 0, 16'h0, 0, 16'h0, "byp_prep");
        applyStimulus(1, 0, 16'h0105, 64'hA5A5, 8'hFF, 1, 16'h0105, 1, 16'h0104, "byp");
        checkOutput("byp_new_value", r_data0, 64'hA5A5);
        checkOutput("byp_old_value", r_data1, 64'h4444);

        // Clear beats a simultaneous write
        applyStimulus(1, 1, 16'h0102, 64'h77, 8'hFF, 1, 16'h0102, 1, 16'h0100, "clr");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 16'h0, 64'h0, 8'h00, 1, 16'(16'h0100 + 2*i), 1,
                          16'(16'h0101 + 2*i), "clr_readback");
        end

        // Asynchronous reset while a read result is pending
        applyStimulus(1, 0, 16'h0100, 64'h1234, 8'hFF, 0, 16'h0, 0, 16'h0, "arst_prep");
        applyStimulus(0, 0, 16'h0, 64'h0, 8'h00, 1, 16'h0100, 0, 16'h0, "arst_read");
        #1;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkAll("arst_mid");
        reset_n = 1'b1;
        applyStimulus(0, 0, 16'h0, 64'h0, 8'h00, 1, 16'h0100, 1, 16'h0100, "arst_after");

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'($urandom), ($urandom_range(0, 31) == 0), pickAddr(),
                          {$urandom, $urandom}, 8'($urandom),
                          1'($urandom), pickAddr(), 1'($urandom), pickAddr(), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
